lc3b_cc_branch_unit: RTL

Consumer end of the ALU result interface. Latches the ALU condition flags into the architectural N/Z/P condition-code register on request. Resolves LC-3b BR instructions against that register using a valid/ready request and response handshake. Produces the taken flag and the PC-relative branch target for the fetch stage.

---
 rtl/lc3b_defs_pkg.sv | 18 +
 rtl/lc3b_cc_reg.sv | 49 ++++
 rtl/lc3b_cc_branch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/lc3b_defs_pkg.sv
// Shared definitions for the LC-3b condition-code / branch resolution slice:
// FSM encodings, CC reset value and default widths.
package lc3b_defs_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_OFF_W  = 9;
    localparam int unsigned DEF_STAT_W = 16;

    // {n,z,p}; Z set out of reset keeps the register one-hot
    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StResp = 2'd2
    } br_state_e;

endpackage

// File: rtl/lc3b_cc_reg.sv
// Architectural N/Z/P condition-code register. Loads the ALU flags when they
// are consistent (one-hot), otherwise re-derives N/Z/P from the result word.
module lc3b_cc_reg
    import lc3b_defs_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_cc,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_positive,
    output logic              cc_n,
    output logic              cc_z,
    output logic              cc_p
);

    logic [2:0] cc_q;
    logic [2:0] cc_d;
    logic [2:0] flags;
    logic       res_zero;
    logic       res_neg;

    always_comb begin
        flags    = {alu_negative, alu_zero, alu_positive};
        res_neg  = alu_result[DATA_W-1];
        res_zero = (alu_result == '0);
        if ($onehot(flags)) begin
            cc_d = flags;
        end else begin
            cc_d = {res_neg, res_zero, !res_neg && !res_zero};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q <= CC_RESET;
        end else if (ld_cc) begin
            cc_q <= cc_d;
        end
    end

    assign cc_n = cc_q[2];
    assign cc_z = cc_q[1];
    assign cc_p = cc_q[0];

endmodule

// File: rtl/lc3b_cc_branch_unit.sv
// LC-3b BR resolution: CC register plus an IDLE/EVAL/RESP handshake FSM that
// returns taken and PC-relative target. Define BR_STATS_EN for taken_count.
module lc3b_cc_branch_unit
    import lc3b_defs_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OFF_W  = DEF_OFF_W
`ifdef BR_STATS_EN
    ,
    parameter int unsigned STAT_W = DEF_STAT_W
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_positive,
    input  logic              alu_negative,
    input  logic              ld_cc,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_nzp,
    input  logic [OFF_W-1:0]  br_offset9,
    input  logic [DATA_W-1:0] br_pc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [DATA_W-1:0] res_target,
    output logic              cc_n,
    output logic              cc_z,
    output logic              cc_p
`ifdef BR_STATS_EN
    ,
    output logic [STAT_W-1:0] taken_count
`endif
);

    br_state_e         state_q;
    logic [2:0]        nzp_q;
    logic [OFF_W-1:0]  offset_q;
    logic [DATA_W-1:0] pc_q;
    logic              taken;
    logic [DATA_W-1:0] target;

    lc3b_cc_reg #(
        .DATA_W (DATA_W)
    ) u_cc_reg (
        .clk          (clk),
        .reset        (reset),
        .ld_cc        (ld_cc),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .alu_zero     (alu_zero),
        .alu_positive (alu_positive),
        .cc_n         (cc_n),
        .cc_z         (cc_z),
        .cc_p         (cc_p)
    );

    // Word offset shifted left by one; the sum wraps modulo 2^DATA_W.
    always_comb begin
        taken  = |(nzp_q & {cc_n, cc_z, cc_p});
        target = pc_q + {{(DATA_W-OFF_W-1){offset_q[OFF_W-1]}}, offset_q, 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            nzp_q      <= '0;
            offset_q   <= '0;
            pc_q       <= '0;
            res_taken  <= 1'b0;
            res_target <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (br_valid) begin
                        nzp_q    <= br_nzp;
                        offset_q <= br_offset9;
                        pc_q     <= br_pc;
                        state_q  <= StEval;
                    end
                end
                StEval: begin
                    res_taken  <= taken;
                    res_target <= target;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign br_ready  = (state_q == StIdle);
    assign res_valid = (state_q == StResp);

`ifdef BR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_count <= '0;
        end else if (res_valid && res_ready && res_taken && (taken_count != '1)) begin
            taken_count <= taken_count + 1'b1;
        end
    end
`endif

endmodule
